// File: rtl/toeplitz_mv_multiplier_pkg.sv
// Shared defaults, counter sizing and FSM state encoding for the
// streaming Toeplitz matrix-vector multiplier.
package toeplitz_mv_multiplier_pkg;

    localparam int N_DEF          = 16;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        LOAD = 1'b0,
        OUT  = 1'b1
    } tmvp_state_e;

    // Beat counter must reach 2N-2 while loading.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/toeplitz_mv_multiplier_if.sv
// Stream bus for the Toeplitz multiplier: operand beats in, result words out.
interface toeplitz_mv_multiplier_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_axis_tdata_row;
    logic [DATA_WIDTH-1:0] s_axis_tdata_vec;
    logic                  s_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;

    modport slave (
        input  s_axis_tdata_row,
        input  s_axis_tdata_vec,
        input  s_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tvalid
    );

    modport master (
        output s_axis_tdata_row,
        output s_axis_tdata_vec,
        output s_axis_tvalid,
        input  m_axis_tdata,
        input  m_axis_tvalid
    );
endinterface

// File: rtl/tmvp_mac_lane.sv
// One lane of the Toeplitz core: a single vector delay stage plus a
// wrap-around multiply-accumulate, both with synchronous clear and enable.
module tmvp_mac_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] row,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] dly_q, dly_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] prod;

    // Product and sum are both truncated to DATA_WIDTH (mod 2^DATA_WIDTH).
    assign prod = row * d_in;

    always_comb begin
        dly_d = dly_q;
        acc_d = acc_q;
        if (clear) begin
            dly_d = '0;
            acc_d = '0;
        end else if (en) begin
            dly_d = d_in;
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_q <= '0;
            acc_q <= '0;
        end else begin
            dly_q <= dly_d;
            acc_q <= acc_d;
        end
    end

    assign d_out = dly_q;
    assign acc   = acc_q;

endmodule

// File: rtl/toeplitz_mv_multiplier.sv
// Streaming Toeplitz matrix-vector multiplier: 2N-1 diagonal beats in,
// N result words out, one lane per output row.
module toeplitz_mv_multiplier
    import toeplitz_mv_multiplier_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    toeplitz_mv_multiplier_if.slave         bus
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] VEC_BEATS = CNT_W'(N);

    tmvp_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   beat_en;
    logic                   clr;
    logic                   out_vld;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [DATA_WIDTH-1:0]  vec_m;
    logic [DATA_WIDTH-1:0]  dly [N+1];
    logic [DATA_WIDTH-1:0]  acc [N];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_en = 1'b0;
        clr     = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.s_axis_tvalid) begin
                    beat_en = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = OUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                // Input beats are ignored here; the lanes stay frozen.
                out_vld = 1'b1;
                if (cnt_q == LAST_OUT) begin
                    clr     = 1'b1;
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Past beat N-1 the vector lane input is forced to zero.
    assign vec_m  = (cnt_q < VEC_BEATS) ? bus.s_axis_tdata_vec : '0;
    assign dly[0] = vec_m;

    for (genvar i = 0; i < N; i++) begin : g_lane
        tmvp_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clr),
            .en    (beat_en),
            .row   (bus.s_axis_tdata_row),
            .d_in  (dly[i]),
            .d_out (dly[i+1]),
            .acc   (acc[i])
        );
    end

    always_comb begin
        out_data = '0;
        if (out_vld) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    out_data = acc[i];
                end
            end
        end
    end

    assign bus.m_axis_tdata  = out_data;
    assign bus.m_axis_tvalid = out_vld;

endmodule

// File: tb/tb_toeplitz_mv_multiplier.sv
// Directed bench for the Toeplitz multiplier with a reference-model scoreboard.
module tb_toeplitz_mv_multiplier;

    localparam int N  = 16;
    localparam int DW = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] r_a [N];
    logic [DW-1:0] c_a [N];
    logic [DW-1:0] v_a [N];

    toeplitz_mv_multiplier_if #(.DATA_WIDTH(DW)) bus ();

    toeplitz_mv_multiplier #(
        .N          (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every valid word is popped from the scoreboard,
    // every idle cycle must present zero data.
    always @(negedge clk) begin
        logic [DW-1:0] exp_v;
        if (bus.m_axis_tvalid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_out observed=%0h required=no_output", bus.m_axis_tdata);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                assert (bus.m_axis_tdata === exp_v)
                else begin
                    errors++;
                    $error("FAIL y_out observed=%0h required=%0h", bus.m_axis_tdata, exp_v);
                end
            end
        end else begin
            checks++;
            assert (bus.m_axis_tvalid === 1'b0 && bus.m_axis_tdata === '0)
            else begin
                errors++;
                $error("FAIL idle_out observed=%0b/%0h required=0/0", bus.m_axis_tvalid, bus.m_axis_tdata);
            end
        end
    end

    task automatic beat(input logic [DW-1:0] row, input logic [DW-1:0] vec, input logic vld);
        bus.s_axis_tdata_row = row;
        bus.s_axis_tdata_vec = vec;
        bus.s_axis_tvalid    = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic push_model();
        logic [DW-1:0] acc;
        logic [DW-1:0] t;
        logic [DW-1:0] prod;
        for (int i = 0; i < N; i++) begin
            acc = '0;
            for (int j = 0; j < N; j++) begin
                t    = (j >= i) ? r_a[j-i] : c_a[i-j];
                prod = t * v_a[j];
                acc  = acc + prod;
            end
            exp_q.push_back(acc);
        end
    endtask

    task automatic send_frame(input int gap_pct, input bit garbage_in_out);
        push_model();
        for (int t = 0; t < 2*N-1; t++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct)
                beat(DW'($urandom), DW'($urandom), 1'b0);
            if (t < N) beat(r_a[N-1-t], v_a[N-1-t], 1'b1);
            else       beat(c_a[t-N+1], DW'($urandom), 1'b1);
        end
        if (garbage_in_out)
            for (int k = 0; k < N; k++) beat(DW'($urandom), DW'($urandom), 1'b1);
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (N + 3) @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL drain_%s observed=%0d_pending required=0", tag, exp_q.size());
        end
    endtask

    task automatic clear_ops();
        for (int k = 0; k < N; k++) begin
            r_a[k] = '0;
            c_a[k] = '0;
            v_a[k] = DW'(k + 1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.s_axis_tdata_row = '0;
        bus.s_axis_tdata_vec = '0;
        bus.s_axis_tvalid    = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (bus.m_axis_tvalid === 1'b0 && bus.m_axis_tdata === '0)
        else begin
            errors++;
            $error("FAIL reset_state observed=%0b/%0h required=0/0", bus.m_axis_tvalid, bus.m_axis_tdata);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Identity
        clear_ops();
        r_a[0] = 8'd1;
        send_frame(0, 1'b0);
        drain("identity");

        // Superdiagonal
        clear_ops();
        r_a[1] = 8'd1;
        send_frame(0, 1'b0);
        drain("superdiag");

        // Subdiagonal, with beats offered during the output phase
        clear_ops();
        c_a[1] = 8'd1;
        send_frame(0, 1'b1);
        drain("subdiag");

        // Wrap-around
        for (int k = 0; k < N; k++) begin
            r_a[k] = 8'hFF;
            c_a[k] = 8'hFF;
            v_a[k] = 8'hFF;
        end
        send_frame(0, 1'b0);
        checks++;
        assert (exp_q.size() == N && exp_q[0] === 8'h10)
        else begin
            errors++;
            $error("FAIL wrap_model observed=%0h required=10", exp_q[0]);
        end
        drain("wrap");

        // Gapped random frames, back to back
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                r_a[k] = DW'($urandom);
                c_a[k] = DW'($urandom);
                v_a[k] = DW'($urandom);
            end
            send_frame(35, 1'b0);
            drain("gapped");
        end

        // Mid-frame reset after beat 10
        for (int t = 0; t <= 10; t++) beat(DW'($urandom), DW'($urandom), 1'b1);
        bus.s_axis_tvalid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        assert (bus.m_axis_tvalid === 1'b0 && bus.m_axis_tdata === '0)
        else begin
            errors++;
            $error("FAIL mid_reset observed=%0b/%0h required=0/0", bus.m_axis_tvalid, bus.m_axis_tdata);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            r_a[k] = 8'd1;
            c_a[k] = 8'd1;
            v_a[k] = 8'd1;
        end
        send_frame(0, 1'b0);
        checks++;
        assert (exp_q.size() == N && exp_q[N-1] === 8'd16)
        else begin
            errors++;
            $error("FAIL ones_model observed=%0h required=10", exp_q[N-1]);
        end
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toeplitz_mv_multiplier.md
Name: toeplitz_mv_multiplier

Overview:
Streaming Toeplitz matrix–vector multiplier (TMVP core) for an N×N Toeplitz matrix T over integers mod 2^DATA_WIDTH.
- Input: one AXI-Stream-like beat per cycle. Each beat carries one matrix diagonal value and, during the first N beats, one vector element.
- Output: y = T·v, streamed as N words, y[0] first.
- Sits between the operand loader and the result sink in the polynomial-multiplication datapath.

Parameters:
N, 16, matrix/vector dimension (≥2).
DATA_WIDTH, 8, element width; all arithmetic is mod 2^DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
s_axis_tdata_row  input  DATA_WIDTH  matrix diagonal value for the current beat
s_axis_tdata_vec  input  DATA_WIDTH  vector element for the current beat (beats 0..N-1 only)
s_axis_tvalid  input  1  beat qualifier
m_axis_tdata  output  DATA_WIDTH  result element
m_axis_tvalid  output  1  result qualifier (no ready; sink must always accept)

Behaviour:
- Matrix definition: T[i][j] = r[j-i] for j≥i, and c[i-j] for i>j. r[0] is the shared corner element; c[0] is unused.
- Frame = 2N-1 valid beats, indexed t = 0..2N-2.
  - Beats t=0..N-1: row = r[N-1-t], vec = v[N-1-t]. Vector arrives reversed, v[N-1] first.
  - Beats t=N..2N-2: row = c[t-N+1]. The vec input is ignored; it is internally forced to 0.
- Beat t carries diagonal d = N-1-t. Lane i (i = 0..N-1) computes acc[i] += row · v[i+d] when 0 ≤ i+d < N; otherwise it adds 0.
- Causal lane realisation:
  - Vector delay line D[0..N-1], with D[0] = masked vec input and D[k] = vec input delayed k valid beats.
  - Lane i multiplies row by D[i].
  - Delay stages and accumulators are cleared at frame start, which provides the out-of-range zeros.
- Only cycles with s_axis_tvalid=1 advance the beat counter, delay line and accumulators. Idle gaps inside a frame are legal and change nothing.
- Arithmetic: products and sums are truncated to DATA_WIDTH bits (wrap-around, no saturation).
- FSM:
  - LOAD: counts 0..2N-2. The valid beat at count 2N-2 moves the FSM to OUT.
  - OUT: drives one result per cycle for N consecutive cycles, y[0]..y[N-1], with m_axis_tvalid=1. The first output cycle is the cycle immediately after the last beat is sampled. After y[N-1], the FSM clears the accumulators and delay line, then returns to LOAD.
  - s_axis_tvalid is ignored in OUT. Beats presented then are dropped.
- Reset (any time, including mid-frame or mid-output):
  - m_axis_tvalid=0, m_axis_tdata=0.
  - Accumulators, delay line and counters are 0; FSM is in LOAD.
  - Deassertion starts a fresh frame.
- m_axis_tdata holds 0 whenever m_axis_tvalid=0.

Decomposition:
- Shared package: DATA_WIDTH/N defaults, counter width $clog2(2N), FSM state enum {LOAD, OUT}.
- One natural sub-module: tmvp_mac_lane, holding one delay stage plus one multiply-accumulate with clear and enable, instantiated N times via generate.
- Top level holds the FSM, the beat counter, vec masking and the output mux/shift.

Test Plan:
- Identity: r[0]=1, all other r and c = 0, v[k]=k+1 → outputs 1,2,…,16; tvalid high for exactly 16 cycles.
- Superdiagonal: r[1]=1, all else 0, v[k]=k+1 → y[i]=v[i+1], giving 2,3,…,16,0.
- Subdiagonal: c[1]=1, all else 0, v[k]=k+1 → y[i]=v[i-1], giving 0,1,…,15.
- Wrap-around: all r, c, v = 0xFF → every y = 16·(0xFF·0xFF mod 256) mod 256 = 0x10.
- Gapped input: random r, c, v with s_axis_tvalid deasserted on random cycles → results equal the software model of the ungapped frame. Two back-to-back frames both match.
- Mid-frame reset: assert reset after beat 10, then send a full all-ones frame → y[i]=16 for all i; no stale output.
